// File: rtl/im_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : im_fetch_pkg
// Brief    : Shared constants and region encoding for the instruction fetch unit.
// Revision : 1.0 - initial release
// ============================================================================
package im_fetch_pkg;

    localparam logic [31:0] c_nop               = 32'h0000_0013;
    localparam int unsigned c_default_user_base = 32'h0000_3000;
    localparam int unsigned c_default_trap_base = 32'h0000_0000;

    typedef enum logic [1:0] {
        REGION_TRAP = 2'd0,
        REGION_USER = 2'd1,
        REGION_NONE = 2'd2
    } region_e;

endpackage : im_fetch_pkg
`default_nettype wire

// File: rtl/imu_bank.sv
`default_nettype none
// ============================================================================
// Module   : imu_bank
// Brief    : Synchronous-read single-port word array with a registered debug tap.
// Revision : 1.0 - initial release
// ============================================================================
module imu_bank #(
    parameter  int DEPTH = 1024,
    parameter  int WIDTH = 32,
    localparam int c_aw  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    input  logic             i_we,
    input  logic [c_aw-1:0]  i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    input  logic [11:0]      i_dbg_addr,
    output logic [WIDTH-1:0] o_dbg_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] r_dbg_rdata;
    logic             w_dbg_hit;
    logic [c_aw-1:0]  w_dbg_idx;

    assign w_dbg_hit = (32'(i_dbg_addr) < 32'(DEPTH));
    assign w_dbg_idx = c_aw'(i_dbg_addr);

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdata     <= '0;
            r_dbg_rdata <= '0;
        end else begin
            if (i_en) begin
                r_rdata <= r_mem[i_addr];
            end
            r_dbg_rdata <= w_dbg_hit ? r_mem[w_dbg_idx] : '0;
        end
    end

    assign o_rdata     = r_rdata;
    assign o_dbg_rdata = r_dbg_rdata;

endmodule : imu_bank
`default_nettype wire

// File: rtl/im_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : im_fetch_unit
// Brief    : One-cycle instruction fetch from user/trap banks with valid/ready
//            response, flush and an independent debug read port.
//            Define IM_FETCH_FAULT_EN to flag misaligned/unmapped fetches.
// Revision : 1.0 - initial release
// ============================================================================
module im_fetch_unit
    import im_fetch_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 16,
    parameter int unsigned USER_BASE  = c_default_user_base,
    parameter int          USER_DEPTH = 1024,
    parameter int          TRAP_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_fault,
    input  logic              rsp_ready,
    input  logic              flush,
    input  logic [11:0]       dbg_addr,
    input  logic              dbg_region,
    output logic [DATA_W-1:0] dbg_dout
);

    localparam int          c_uaw      = (USER_DEPTH > 1) ? $clog2(USER_DEPTH) : 1;
    localparam int          c_taw      = (TRAP_DEPTH > 1) ? $clog2(TRAP_DEPTH) : 1;
    localparam int unsigned c_user_end = USER_BASE + 4 * USER_DEPTH;

    region_e           w_region;
    logic              w_accept;
    logic              w_fault;
    logic [ADDR_W-1:0] w_user_off;
    logic [c_uaw-1:0]  w_user_idx;
    logic [c_taw-1:0]  w_trap_idx;
    logic              w_user_en;
    logic              w_trap_en;
    logic [DATA_W-1:0] w_user_q;
    logic [DATA_W-1:0] w_trap_q;
    logic [DATA_W-1:0] w_user_dbg;
    logic [DATA_W-1:0] w_trap_dbg;

    logic              r_rsp_valid;
    logic              r_fault;
    logic              r_sel_trap;
    logic              r_dbg_region;

    always_comb begin
        w_region = REGION_NONE;
        if (req_addr[ADDR_W-1:12] == '0) begin
            w_region = REGION_TRAP;
        end else if ((32'(req_addr) >= USER_BASE) && (32'(req_addr) < c_user_end)) begin
            w_region = REGION_USER;
        end
    end

    // Unmapped addresses alias into the user bank, so the modulo covers both.
    assign w_user_off = req_addr - ADDR_W'(USER_BASE);
    assign w_user_idx = c_uaw'((32'(w_user_off) >> 2) % 32'(USER_DEPTH));
    assign w_trap_idx = c_taw'(req_addr >> 2);

`ifdef IM_FETCH_FAULT_EN
    logic w_misaligned;
    assign w_misaligned = (req_addr[1:0] != 2'b00);
    assign w_fault      = w_misaligned || (w_region == REGION_NONE);
`else
    assign w_fault      = 1'b0;
`endif

    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;
    assign w_user_en = w_accept && (w_region != REGION_TRAP);
    assign w_trap_en = w_accept && (w_region == REGION_TRAP);

    imu_bank #(
        .DEPTH (USER_DEPTH),
        .WIDTH (DATA_W)
    ) u_user_bank (
        .clk         (clk),
        .rstn        (rstn),
        .i_en        (w_user_en),
        .i_we        (1'b0),
        .i_addr      (w_user_idx),
        .i_wdata     ({DATA_W{1'b0}}),
        .o_rdata     (w_user_q),
        .i_dbg_addr  (dbg_addr),
        .o_dbg_rdata (w_user_dbg)
    );

    imu_bank #(
        .DEPTH (TRAP_DEPTH),
        .WIDTH (DATA_W)
    ) u_trap_bank (
        .clk         (clk),
        .rstn        (rstn),
        .i_en        (w_trap_en),
        .i_we        (1'b0),
        .i_addr      (w_trap_idx),
        .i_wdata     ({DATA_W{1'b0}}),
        .o_rdata     (w_trap_q),
        .i_dbg_addr  (dbg_addr),
        .o_dbg_rdata (w_trap_dbg)
    );

    // A new accept wins over flush so the fresh response replaces the old one.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsp_valid  <= 1'b0;
            r_fault      <= 1'b0;
            r_sel_trap   <= 1'b0;
            r_dbg_region <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_fault     <= w_fault;
                r_sel_trap  <= (w_region == REGION_TRAP);
            end else if (flush || rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
            r_dbg_region <= dbg_region;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_fault = r_fault;
    assign rsp_data  = r_fault    ? DATA_W'(c_nop) :
                       r_sel_trap ? w_trap_q       : w_user_q;
    assign dbg_dout  = r_dbg_region ? w_trap_dbg : w_user_dbg;

endmodule : im_fetch_unit
`default_nettype wire

// File: doc/im_fetch_unit.md
IM_FETCH_UNIT -- requirements
Module: im_fetch_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, byte address width.
REQ-003 SHALL have parameter USER_BASE, default 16'h3000, byte base of the user program region.
REQ-004 SHALL have parameter USER_DEPTH, default 1024, user region depth in words.
REQ-005 SHALL have parameter TRAP_DEPTH, default 256, trap region depth in words; trap region based at byte 0.
REQ-006 SHALL have ports, clock and reset first (one clock; reset asynchronous, active-low):
- clk  in  1  sole clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  fetch request
- req_addr  in  ADDR_W  fetch byte address
- req_ready  out  1  request accepted when high with req_valid
- rsp_valid  out  1  response held
- rsp_data  out  DATA_W  fetched instruction
- rsp_fault  out  1  response is a fault
- rsp_ready  in  1  consumer takes response
- flush  in  1  discard held response
- dbg_addr  in  12  debug word index
- dbg_region  in  1  debug bank: 0 user, 1 trap
- dbg_dout  out  DATA_W  debug read data

Function
REQ-007 SHALL decode: trap if req_addr[ADDR_W-1:12]==0; user if USER_BASE <= req_addr < USER_BASE+4*USER_DEPTH; otherwise unmapped.
REQ-008 SHALL index user bank with (req_addr-USER_BASE)>>2 and trap bank with req_addr>>2.
REQ-009 SHALL drive req_ready = !rsp_valid || rsp_ready.
REQ-010 SHALL, on accept (req_valid && req_ready), present the response on the next rising edge: rsp_valid=1, data from the selected bank; latency exactly 1 cycle.
REQ-011 SHALL hold rsp_valid, rsp_data, rsp_fault stable while rsp_valid && !rsp_ready.
REQ-012 SHALL clear rsp_valid after rsp_valid && rsp_ready with no new accept; back-to-back accepts SHALL sustain one response per cycle.
REQ-013 SHALL, on flush, clear rsp_valid next edge; flush together with accept SHALL discard the old response and deliver the new one.
REQ-014 SHALL register dbg_dout one cycle after dbg_addr/dbg_region, independent of the fetch path, never stalling it.
REQ-015 SHALL treat debug indices beyond the selected bank depth as reading 0.

Reset
REQ-016 SHALL, while rstn=0, force rsp_valid=0, rsp_data=0, rsp_fault=0, dbg_dout=0, asynchronously.
REQ-017 SHALL discard any in-flight response on reset assertion mid-transfer; first accept after release is serviced normally.
REQ-018 SHALL NOT reset memory contents.

Configuration
REQ-019 SHALL, with IM_FETCH_FAULT_EN defined, flag rsp_fault=1 and rsp_data=NOP (32'h00000013) for misaligned (req_addr[1:0]!=0) or unmapped addresses.
REQ-020 SHALL, without IM_FETCH_FAULT_EN, tie rsp_fault to 0, ignore req_addr[1:0], and read the user bank with the index wrapped modulo USER_DEPTH for unmapped addresses.

Structure
REQ-021 SHALL place the NOP constant, region enum (REGION_TRAP, REGION_USER, REGION_NONE) and default bases in package im_fetch_pkg.
REQ-022 SHALL instantiate sub-module imu_bank (synchronous-read single-port array, parameter DEPTH, WIDTH) twice: user and trap.

Verification
REQ-023 Preload user[0]=32'h00500093; req 16'h3000 -> next cycle rsp_valid=1, rsp_data=32'h00500093, rsp_fault=0.
REQ-024 Preload trap[4]=32'h30200073; req 16'h0010 -> rsp_data=32'h30200073.
REQ-025 rsp_ready=0 for 3 cycles after response -> req_ready=0, rsp_data stable; rsp_ready=1 -> next request accepted same cycle.
REQ-026 FAULT_EN set: req 16'h3002 -> rsp_fault=1, rsp_data=32'h00000013; req 16'hF000 -> rsp_fault=1.
REQ-027 Response held, flush with new req 16'h3004 -> old response dropped, next rsp_data=user[1].
REQ-028 rstn low with rsp_valid=1 -> rsp_valid=0 immediately; dbg_region=1, dbg_addr=4 -> dbg_dout=trap[4] one cycle later.
